// File: rtl/pid_seq.sv
// PID controller sharing one signed multiplier across P, I and D terms.
// A five-state sequencer computes one term per cycle, then sums them into a saturated drive command.
module pid_seq #(
    parameter logic [3:0] P_COEFF = 4'h8,
    parameter logic [3:0] D_COEFF = 4'h7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] error,
    input  logic        err_vld,
    input  logic        moving,
    output logic [11:0] drv,
    output logic        drv_vld,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PTERM = 3'd1,
        ITERM = 3'd2,
        DTERM = 3'd3,
        SUM   = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [9:0]  err_sat_q, err_sat_d;
    logic        moving_q, moving_d;
    logic [13:0] p_q, p_d;
    logic [11:0] i_q, i_d;
    logic [13:0] d_q, d_d;
    logic [15:0] integ_q, integ_d;
    logic [9:0]  prev_err_q, prev_err_d;
    logic [11:0] drv_q, drv_d;
    logic        drv_vld_q, drv_vld_d;

    // FSM control strobes
    logic cap_en, p_en, i_en, d_en, sum_en, sel_d;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (err_vld) state_d = PTERM;
            PTERM:   state_d = ITERM;
            ITERM:   state_d = DTERM;
            DTERM:   state_d = SUM;
            SUM:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM outputs ----------------
    always_comb begin
        cap_en = 1'b0;
        p_en   = 1'b0;
        i_en   = 1'b0;
        d_en   = 1'b0;
        sum_en = 1'b0;
        sel_d  = 1'b0;
        busy   = 1'b1;
        case (state_q)
            IDLE:    begin busy = 1'b0; cap_en = err_vld; end
            PTERM:   p_en = 1'b1;
            ITERM:   i_en = 1'b1;
            DTERM:   begin d_en = 1'b1; sel_d = 1'b1; end
            SUM:     sum_en = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // ---------------- input saturation ----------------
    logic signed [11:0] err_s;
    logic [9:0]         err_sat;

    always_comb begin
        err_s = error;
        if (err_s > 12'sd511)       err_sat = 10'h1FF;
        else if (err_s < -12'sd512) err_sat = 10'h200;
        else                        err_sat = error[9:0];
    end

    // ---------------- derivative difference ----------------
    logic signed [10:0] diff;
    logic [7:0]         diff_sat;

    always_comb begin
        diff = $signed({err_sat_q[9], err_sat_q}) - $signed({prev_err_q[9], prev_err_q});
        if (diff > 11'sd127)       diff_sat = 8'h7F;
        else if (diff < -11'sd128) diff_sat = 8'h80;
        else                       diff_sat = diff[7:0];
    end

    // ---------------- shared multiplier ----------------
    // Operands are widened to 14 bits; legal coefficients keep the product in range.
    logic [9:0]         mul_a;
    logic [4:0]         mul_b;
    logic signed [13:0] mul_a14, mul_b14, mul_p;

    always_comb begin
        mul_a   = sel_d ? {{2{diff_sat[7]}}, diff_sat} : err_sat_q;
        mul_b   = sel_d ? {1'b0, D_COEFF} : {1'b0, P_COEFF};
        mul_a14 = $signed({{4{mul_a[9]}}, mul_a});
        mul_b14 = $signed({9'd0, mul_b});
        mul_p   = mul_a14 * mul_b14;
    end

    // ---------------- integrator ----------------
    logic [15:0] err_ext, integ_sum, integ_next;
    logic        integ_ovf;

    always_comb begin
        err_ext    = {{6{err_sat_q[9]}}, err_sat_q};
        integ_sum  = integ_q + err_ext;
        integ_ovf  = (integ_q[15] == err_ext[15]) && (integ_sum[15] != integ_q[15]);
        if (!moving_q)      integ_next = 16'd0;
        else if (integ_ovf) integ_next = integ_q;
        else                integ_next = integ_sum;
    end

    // ---------------- final sum ----------------
    logic signed [14:0] total;
    logic [11:0]        total_sat;

    always_comb begin
        total = $signed({p_q[13], p_q}) + $signed({{3{i_q[11]}}, i_q}) + $signed({d_q[13], d_q});
        if (total > 15'sd2047)       total_sat = 12'h7FF;
        else if (total < -15'sd2048) total_sat = 12'h800;
        else                         total_sat = total[11:0];
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        err_sat_q_hold();
    end

    function automatic void err_sat_q_hold();
    endfunction

    always_comb begin
        err_sat_d  = err_sat_q;
        moving_d   = moving_q;
        p_d        = p_q;
        i_d        = i_q;
        d_d        = d_q;
        integ_d    = integ_q;
        prev_err_d = prev_err_q;
        drv_d      = drv_q;
        drv_vld_d  = 1'b0;
        if (cap_en) begin
            err_sat_d = err_sat;
            moving_d  = moving;
        end
        if (p_en) p_d = mul_p;
        if (i_en) begin
            integ_d = integ_next;
            i_d     = integ_next[15:4];
        end
        if (d_en) begin
            d_d        = mul_p;
            prev_err_d = err_sat_q;
        end
        if (sum_en) begin
            drv_d     = total_sat;
            drv_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sat_q  <= '0;
            moving_q   <= 1'b0;
            p_q        <= '0;
            i_q        <= '0;
            d_q        <= '0;
            integ_q    <= '0;
            prev_err_q <= '0;
            drv_q      <= '0;
            drv_vld_q  <= 1'b0;
        end else begin
            err_sat_q  <= err_sat_d;
            moving_q   <= moving_d;
            p_q        <= p_d;
            i_q        <= i_d;
            d_q        <= d_d;
            integ_q    <= integ_d;
            prev_err_q <= prev_err_d;
            drv_q      <= drv_d;
            drv_vld_q  <= drv_vld_d;
        end
    end

    assign drv     = drv_q;
    assign drv_vld = drv_vld_q;

endmodule

// File: tb/tb_pid_seq.sv
// Randomised and directed bench for pid_seq against a cycle-numbered arithmetic model.
module tb_pid_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] error = '0;
    logic        err_vld = 1'b0;
    logic        moving = 1'b1;
    logic [11:0] drv;
    logic        drv_vld;
    logic        busy;

    pid_seq dut (
        .clk(clk), .rst_n(rst_n), .error(error), .err_vld(err_vld),
        .moving(moving), .drv(drv), .drv_vld(drv_vld), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    // Model: an accepted sample's result is computed at once and scheduled
    // for the cycle five after acceptance.
    int cur = 0, due = -1, acc = -100, free_at = 0;
    int m_int = 0, m_prev = 0, pend = 0, exp_drv = 0;

    always @(posedge clk) begin
        int es, p, iv, d, s;
        if (!rst_n) begin
            m_int = 0; m_prev = 0; due = -1; acc = -100; free_at = 0; exp_drv = 0;
        end else if (err_vld && cur >= free_at) begin
            es = clamp($signed(error), -512, 511);
            p  = es * 8;
            if (!moving) m_int = 0;
            else begin
                s = m_int + es;
                if (s >= -32768 && s <= 32767) m_int = s;
            end
            iv = (m_int - (((m_int % 16) + 16) % 16)) / 16;
            d  = clamp(es - m_prev, -128, 127) * 7;
            m_prev = es;
            pend = clamp(p + iv + d, -2048, 2047);
            acc = cur; due = cur + 5; free_at = cur + 5;
        end
        cur++;
        if (rst_n && cur == due) exp_drv = pend;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", busy, (cur > acc && cur <= acc + 4) ? 1 : 0);
            check("drv_vld", drv_vld, (cur == due) ? 1 : 0);
            check("drv", $signed(drv), exp_drv);
            if (cur == due) begin
                check("integrator", $signed(dut.integ_q), m_int);
                check("prev_err", $signed(dut.prev_err_q), m_prev);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0; err_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send(input logic [11:0] e, input logic m, output int res);
        int k;
        bit got;
        @(posedge clk); #1 error = e; moving = m; err_vld = 1'b1;
        @(posedge clk); #1 err_vld = 1'b0;
        got = 0; k = 0;
        for (int j = 0; j < 8 && !got; j++) begin
            @(negedge clk); k++;
            if (drv_vld) got = 1;
        end
        check("latency", got ? k : -1, 5);
        res = $signed(drv);
    endtask

    task automatic count_vld(input int cycles, output int n);
        n = 0;
        for (int j = 0; j < cycles; j++) begin
            @(negedge clk);
            if (drv_vld) n++;
        end
    endtask

    initial begin
        int r, n;
        repeat (2) @(negedge clk);
        check("rst_drv", $signed(drv), 0);
        check("rst_busy", busy, 0);
        check("rst_vld", drv_vld, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        send(12'd16, 1'b1, r);  check("p16_first", r, 241);
        send(12'd16, 1'b1, r);  check("p16_repeat", r, 130);
        check("int_after_2", $signed(dut.integ_q), 32);

        do_reset();
        send(12'h7FF, 1'b1, r); check("pos_sat", r, 2047);
        do_reset();
        send(12'h800, 1'b1, r); check("neg_sat", r, -2048);
        check("neg_I", $signed(dut.i_q), -32);

        do_reset();
        for (int s = 1; s <= 70; s++) begin
            send(12'h1FF, 1'b1, r);
            if (s == 64) check("int_64", $signed(dut.integ_q), 32704);
        end
        check("int_hold", $signed(dut.integ_q), 32704);
        check("I_hold", $signed(dut.i_q), 2044);
        send(12'h1FF, 1'b0, r);
        check("int_clear", $signed(dut.integ_q), 0);
        check("I_clear", $signed(dut.i_q), 0);

        // second strobe while busy must be dropped
        @(posedge clk); #1 error = 12'd100; moving = 1'b1; err_vld = 1'b1;
        @(posedge clk); #1 err_vld = 1'b0;
        @(posedge clk); #1 error = 12'hED4; err_vld = 1'b1;
        @(posedge clk); #1 err_vld = 1'b0;
        count_vld(10, n); check("busy_drop_pulses", n, 1);

        // reset during ITERM abandons the sample
        @(posedge clk); #1 error = 12'd16; moving = 1'b1; err_vld = 1'b1;
        @(posedge clk); #1 err_vld = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        count_vld(8, n); check("abort_pulses", n, 0);
        check("abort_drv", $signed(drv), 0);
        send(12'd16, 1'b1, r); check("post_abort", r, 241);

        // random traffic, including back-to-back strobes and strobes while busy
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            err_vld = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0: error = 12'($urandom_range(0, 4095));
                1: error = $urandom_range(0, 1) ? 12'h7FF : 12'h800;
                2: error = 12'($urandom_range(0, 40)) - 12'd20;
                default: error = $urandom_range(0, 1) ? 12'h1FF : 12'hE00;
            endcase
            moving = ($urandom_range(0, 7) != 0);
            if (c == 700) begin rst_n = 1'b0; end
            if (c == 702) begin rst_n = 1'b1; end
        end
        @(posedge clk); #1 err_vld = 1'b0;
        repeat (8) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
